// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, sync payload type and width helpers.
package vga_pkg;

  // Default 640x480 @ 60 Hz timing
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Sync payload carried through the alignment delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  // Total period of one axis: active + porches + sync
  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to hold 0..n-1, never less than one
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator to the pixel pipeline.
interface vga_timing_gen_if #(
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 10,
  parameter int unsigned FRAME_W = 8
);

  logic               pix_stb;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic               hs;
  logic               vs;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic               animate;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output pix_stb, x, y, hs, vs, de, line_start, frame_start, animate, frame_cnt
  );

  modport slave (
    input pix_stb, x, y, hs, vs, de, line_start, frame_start, animate, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Strobe-enabled shift register aligning sync/enable with the pixel pipeline.
module vga_sync_delay #(
  parameter int unsigned    DEPTH   = 0,
  parameter int unsigned    W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] sr [DEPTH];

    // Shift one stage per pixel strobe; reset flushes every stage
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else if (en) begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel divider, h/v counters, sync decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned PIPE_DLY = 0,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_BTN,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned XW      = clog2w(H_TOTAL);
  localparam int unsigned YW      = clog2w(V_TOTAL);
  localparam int unsigned DW      = clog2w(CLK_DIV);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  localparam vga_sync_t SYNC_RST = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

  logic [DW-1:0]      div_cnt;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [FRAME_W-1:0] frame_q;
  logic               animate_q;
  logic               pix_stb;
  logic               x_last;
  logic               y_last;
  logic [31:0]        x_ext;
  logic [31:0]        y_ext;
  vga_sync_t          sync_raw;
  vga_sync_t          sync_dly;

  assign pix_stb = (div_cnt == DW'(CLK_DIV - 1));
  assign x_last  = (x_q == XW'(H_TOTAL - 1));
  assign y_last  = (y_q == YW'(V_TOTAL - 1));

  // Pixel strobe divider: free-running modulo CLK_DIV
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      div_cnt <= '0;
    end else if (pix_stb) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Raster counters and completed-frame count, advanced per pixel
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else if (pix_stb) begin
      if (x_last) begin
        x_q <= '0;
        if (y_last) begin
          y_q     <= '0;
          frame_q <= frame_q + FRAME_W'(1);
        end else begin
          y_q <= y_q + YW'(1);
        end
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // One-clock pulse after the last visible pixel of each frame
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      animate_q <= 1'b0;
    end else begin
      animate_q <= pix_stb && (x_q == XW'(H_ACTIVE - 1)) && (y_q == YW'(V_ACTIVE - 1));
    end
  end

  assign x_ext = 32'(x_q);
  assign y_ext = 32'(y_q);

  // Undelayed sync / enable decode straight from the counter registers
  always_comb begin
    sync_raw    = SYNC_RST;
    sync_raw.hs = (x_ext >= HS_BEG && x_ext < HS_END) ? H_POL : ~H_POL;
    sync_raw.vs = (y_ext >= VS_BEG && y_ext < VS_END) ? V_POL : ~V_POL;
    sync_raw.de = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
  end

  vga_sync_delay #(
    .DEPTH   (PIPE_DLY),
    .W       ($bits(vga_sync_t)),
    .RST_VAL (SYNC_RST)
  ) u_sync_delay (
    .clk (CLK),
    .rst (RST_BTN),
    .en  (pix_stb),
    .d   (sync_raw),
    .q   (sync_dly)
  );

  assign vga.pix_stb     = pix_stb;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hs          = sync_dly.hs;
  assign vga.vs          = sync_dly.vs;
  assign vga.de          = sync_dly.de;
  assign vga.line_start  = (x_q == '0);
  assign vga.frame_start = (x_q == '0) && (y_q == '0);
  assign vga.animate     = animate_q;
  assign vga.frame_cnt   = frame_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and successor to the fixed 640x480 timing block inside `top`. It derives a pixel strobe from the system clock and runs horizontal/vertical counters. From those it produces sync, data-enable, coordinates, line/frame markers and a frame counter. Resolution, porches, sync polarity, clock divider and output pipeline alignment are all set by parameters. It sits between the clock domain and the pixel pipeline that drives `VGA_R/G/B`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `H_POL`, 0: hsync asserted level (0 = active-low)
- `V_POL`, 0: vsync asserted level
- `CLK_DIV`, 4: system clocks per pixel; legal range is 1..16
- `PIPE_DLY`, 0: pixel-strobe delay applied to hs/vs/de; legal range is 0..4
- `FRAME_W`, 8: frame counter width
- `CLK` in 1: system clock; the only clock
- `RST_BTN` in 1: reset, synchronous, active-high
- `pix_stb` out 1: one-CLK pixel enable
- `x` out XW: horizontal count, XW = clog2(H_TOTAL)
- `y` out YW: vertical count, YW = clog2(V_TOTAL)
- `hs` out 1: horizontal sync, polarity applied, delayed by PIPE_DLY
- `vs` out 1: vertical sync, polarity applied, delayed by PIPE_DLY
- `de` out 1: active-video enable, delayed by PIPE_DLY
- `line_start` out 1: high while x==0 (undelayed)
- `frame_start` out 1: high while x==0 and y==0 (undelayed)
- `animate` out 1: one-CLK pulse on the pix_stb where x==H_ACTIVE-1 and y==V_ACTIVE-1
- `frame_cnt` out FRAME_W: completed frames, wraps modulo 2^FRAME_W

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800 and 525.
- Line order: active region, then front porch, sync, back porch.
- Active region: x in 0..H_ACTIVE-1. Sync region: x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751 by default.
- Vertical sync region: y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491 by default.
- Divider: `div_cnt` counts 0..CLK_DIV-1 each CLK. pix_stb = (div_cnt==CLK_DIV-1). When CLK_DIV=1, pix_stb is constantly high out of reset.
- Counter advance: x and y change only on a CLK edge where pix_stb=1.
- x wraps from H_TOTAL-1 to 0 and y increments. At x==H_TOTAL-1 and y==V_TOTAL-1, both wrap to 0 and frame_cnt increments in the same edge.
- Undecoded sync: hs_raw = H_POL when in the hsync region, else ~H_POL. vs_raw is formed the same way with V_POL. de_raw = (x<H_ACTIVE && y<V_ACTIVE).
- Delay line: a PIPE_DLY-deep shift register on {hs,vs,de}, advanced on pix_stb only. With PIPE_DLY=0 the outputs are the raw decodes of the counter registers.
- The delay applies only to hs/vs/de. x/y/line_start/frame_start are never delayed, so the pixel pipeline samples x/y and its output aligns with the delayed de.

## Timing
- Reset values: div_cnt=0, x=0, y=0, frame_cnt=0, animate=0.
- Delay stages reset to de=0 and hs/vs at their inactive level (~H_POL/~V_POL).
- With PIPE_DLY=0, the cycle after reset shows de=1, line_start=1, frame_start=1, and hs/vs inactive.
- The first pix_stb occurs in the CLK_DIV-th cycle after RST_BTN falls.
- All state is registered. Decoded outputs are combinational from registers only, with no input-to-output paths.
- animate is registered and is high for exactly one CLK per frame, in the CLK after the qualifying pix_stb edge.
- Reset asserted mid-frame takes effect on the next CLK edge regardless of pix_stb. It returns all state to the reset values and flushes the delay line. No partial frame_cnt increment occurs.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV CLKs: 1,680,000 with defaults.

## Structure
- Package `vga_pkg`: default 640x480 timing constants, a function computing H_TOTAL/V_TOTAL, and the clog2 width helper.
- Sub-module `vga_sync_delay`: a parametrised-depth, strobe-enabled shift register with per-bit reset values, used for {hs,vs,de}.
- Divider, counters and decode live in `vga_timing_gen`.

## Test plan
- **Reset:** hold RST_BTN for 5 CLKs with defaults, then release. Required: x=0, y=0, de=1, hs=1, vs=1, frame_cnt=0, and the first pix_stb on the 4th CLK after release.
- **Horizontal sync:** default parameters, run one line. Required: hs=0 exactly for x=656..751, de=0 for x≥640, pix_stb spacing of 4 CLKs, and x wrapping 799→0 with y incrementing.
- **Frame wrap:** small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1), run 3 frames. Required: vs low on y=5 only, frame_start every 98 CLKs, animate once per frame at x=7/y=3, frame_cnt reaching 3.
- **Polarity and pipeline delay:** H_POL=1, V_POL=1, PIPE_DLY=2. Required: hs high for the sync region, with de/hs/vs transitions lagging their undelayed decodes by exactly 2 pix_stb.
- **Reset mid-frame:** assert RST_BTN at x=300, y=200 with PIPE_DLY=3. Required: next CLK shows x=0, y=0, delayed de=0, and frame_cnt unchanged at 0.
- **Frame counter wrap:** FRAME_W=2, run 5 frames. Required: frame_cnt sequence 1, 2, 3, 0, 1.
